// File: rtl/wb_pwm_slave_if.sv
// Wishbone slave-side bundle for one PWM timer port of the bus splitter.
// The master modport is what the splitter (or a bench) drives.
interface wb_pwm_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  cyc;
    logic                  stb;
    logic                  ack;
    logic                  err;

    modport master (
        output adr, dat_w, we, sel, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, we, sel, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_pwm_slave.sv
// Wishbone PWM timer: register file, prescaler, counter with shadowed
// period/compare reloaded at wrap, and a W1C wrap flag driving irq.
module wb_pwm_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int PRE_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_pwm_slave_if.slave s_wb,
    output logic          pwm_out,
    output logic          irq
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_PRE   = 3'd1;
    localparam logic [2:0] OFF_PER   = 3'd2;
    localparam logic [2:0] OFF_CMP   = 3'd3;
    localparam logic [2:0] OFF_STAT  = 3'd4;
    localparam logic [2:0] OFF_COUNT = 3'd5;

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRE_WIDTH-1:0]  prescale_q, prescale_d;
    logic [PRE_WIDTH-1:0]  pre_lim_q, pre_lim_d;
    logic [PRE_WIDTH-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0]  period_sh_q, period_sh_d;
    logic [CNT_WIDTH-1:0]  cmp_sh_q, cmp_sh_d;
    logic [CNT_WIDTH-1:0]  period_act_q, period_act_d;
    logic [CNT_WIDTH-1:0]  cmp_act_q, cmp_act_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  pwm_q, pwm_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_r_q, dat_r_d;

    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rdata;
    logic [2:0]            off;
    logic                  req, mapped, wr_en, tick, wrap_evt, en, pol;

    assign off    = s_wb.adr[4:2];
    assign req    = s_wb.cyc & s_wb.stb & ~ack_q & ~err_q;
    assign mapped = (off < 3'd6);
    assign wr_en  = req & mapped & s_wb.we;
    assign en     = ctrl_q[0];
    assign pol    = ctrl_q[1];

    // Upper address bits were already decoded by the splitter.
    logic unused_adr;
    assign unused_adr = ^{s_wb.adr[ADDR_WIDTH-1:5], s_wb.adr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
            assign wmask[gi*8 +: 8] = {8{s_wb.sel[gi]}};
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:  rdata = DATA_WIDTH'(ctrl_q);
            OFF_PRE:   rdata = DATA_WIDTH'(prescale_q);
            OFF_PER:   rdata = DATA_WIDTH'(period_sh_q);
            OFF_CMP:   rdata = DATA_WIDTH'(cmp_sh_q);
            OFF_STAT:  rdata = DATA_WIDTH'(wrap_q);
            OFF_COUNT: rdata = DATA_WIDTH'(cnt_q);
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        prescale_d   = prescale_q;
        period_sh_d  = period_sh_q;
        cmp_sh_d     = cmp_sh_q;
        wrap_d       = wrap_q;
        pre_cnt_d    = pre_cnt_q;
        pre_lim_d    = pre_lim_q;
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        cmp_act_d    = cmp_act_q;
        tick         = 1'b0;
        wrap_evt     = 1'b0;

        if (wr_en) begin
            case (off)
                OFF_CTRL: ctrl_d      = 3'(merge_bytes(DATA_WIDTH'(ctrl_q), s_wb.dat_w, wmask));
                OFF_PRE:  prescale_d  = PRE_WIDTH'(merge_bytes(DATA_WIDTH'(prescale_q), s_wb.dat_w, wmask));
                OFF_PER:  period_sh_d = CNT_WIDTH'(merge_bytes(DATA_WIDTH'(period_sh_q), s_wb.dat_w, wmask));
                OFF_CMP:  cmp_sh_d    = CNT_WIDTH'(merge_bytes(DATA_WIDTH'(cmp_sh_q), s_wb.dat_w, wmask));
                OFF_STAT: if (s_wb.sel[0] && s_wb.dat_w[0]) wrap_d = 1'b0;
                default:  ;
            endcase
        end

        if (!en) begin
            // Idle: everything parked so enabling starts a clean period.
            pre_cnt_d    = '0;
            pre_lim_d    = prescale_q;
            cnt_d        = '0;
            period_act_d = period_sh_q;
            cmp_act_d    = cmp_sh_q;
        end else begin
            if (pre_cnt_q == pre_lim_q) begin
                tick      = 1'b1;
                pre_cnt_d = '0;
                pre_lim_d = prescale_q;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
            end
            if (tick) begin
                if (cnt_q == period_act_q) begin
                    wrap_evt     = 1'b1;
                    cnt_d        = '0;
                    period_act_d = period_sh_q;
                    cmp_act_d    = cmp_sh_q;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end

        // A wrap beats a same-edge clear so no wrap is ever missed.
        if (wrap_evt) wrap_d = 1'b1;

        pwm_d   = en ? ((cnt_q < cmp_act_q) ^ pol) : pol;
        ack_d   = req & mapped;
        err_d   = req & ~mapped;
        dat_r_d = (req & mapped) ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            prescale_q   <= '0;
            pre_lim_q    <= '0;
            pre_cnt_q    <= '0;
            period_sh_q  <= '0;
            cmp_sh_q     <= '0;
            period_act_q <= '0;
            cmp_act_q    <= '0;
            cnt_q        <= '0;
            wrap_q       <= 1'b0;
            pwm_q        <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_r_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            prescale_q   <= prescale_d;
            pre_lim_q    <= pre_lim_d;
            pre_cnt_q    <= pre_cnt_d;
            period_sh_q  <= period_sh_d;
            cmp_sh_q     <= cmp_sh_d;
            period_act_q <= period_act_d;
            cmp_act_q    <= cmp_act_d;
            cnt_q        <= cnt_d;
            wrap_q       <= wrap_d;
            pwm_q        <= pwm_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_r_q      <= dat_r_d;
        end
    end

    assign s_wb.ack   = ack_q;
    assign s_wb.err   = err_q;
    assign s_wb.dat_r = dat_r_q;
    assign pwm_out    = pwm_q;
    assign irq        = wrap_q & ctrl_q[2];
endmodule

// File: tb/tb_wb_pwm_slave.sv
// Randomized bench for wb_pwm_slave; the PWM/irq reference is computed
// arithmetically from the enable edge, prescale, period and compare values.
module tb_wb_pwm_slave;
    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_PRE   = 32'h04;
    localparam logic [31:0] A_PER   = 32'h08;
    localparam logic [31:0] A_CMP   = 32'h0C;
    localparam logic [31:0] A_STAT  = 32'h10;
    localparam logic [31:0] A_COUNT = 32'h14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_out, irq;
    int   ecnt = 0;
    int   total = 0;
    int   bad = 0;
    logic last_ack, last_err, last_irq;

    wb_pwm_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    wb_pwm_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .PRE_WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_wb    (bus),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    // One Wibshone access; upper address bits are random noise.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int edge_idx);
        logic [31:0] noise;
        logic        mapped;
        noise = $urandom;
        @(posedge clk); #1;
        bus.adr = {noise[31:5], adr[4:0]};
        bus.we = we; bus.dat_w = wdat; bus.sel = sel;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        @(posedge clk); #1;
        last_ack = bus.ack; last_err = bus.err; last_irq = irq;
        rdat = bus.dat_r; edge_idx = ecnt;
        bus_idle();
        mapped = (adr[4:2] < 3'd6);
        chk_val("ack", 32'(last_ack), 32'(mapped));
        chk_val("err", 32'(last_err), 32'(!mapped));
        @(posedge clk); #1;
        chk_val("ack_1cyc", 32'({bus.ack, bus.err}), 32'd0);
        $display("wb %s adr=%h dat=%h sel=%b ack=%0b err=%0b rd=%h",
                 we ? "WR" : "RD", adr, wdat, sel, last_ack, last_err, rdat);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] d; int e;
        wb_xfer(adr, 1'b1, wdat, sel, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d; int e;
        wb_xfer(adr, 1'b0, 32'h0, 4'hF, d, e);
        chk_val(tag, d, exp);
    endtask

    // Enable with the given settings, then compare pwm/irq each cycle to
    // closed-form expectations; optionally rewrite CMP mid-run.
    task automatic run_trial(input int p, input int n, input int c, input bit pol, input bit ien,
                             input int mid, input int cnew, input int ncyc, input int exp_hi);
        logic [31:0] d;
        int t0, e, e1, w, lw, tw, cnt, cmpe, hi;
        bit exp_pwm, exp_irq;
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STAT, 32'h1, 4'h1);
        wr(A_PRE, 32'(p), 4'hF);
        wr(A_PER, 32'(n), 4'hF);
        wr(A_CMP, 32'(c), 4'hF);
        wb_xfer(A_CTRL, 1'b1, 32'(1 | (int'(pol) << 1) | (int'(ien) << 2)), 4'hF, d, t0);
        w = (p + 1) * (n + 1);
        tw = -1;
        hi = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            e = ecnt;
            if (tw >= 0 && e == tw) bus_idle();
            e1 = e - 1 - t0;
            lw = t0 + (e1 / w) * w;
            cmpe = (tw >= 0 && lw > tw) ? cnew : c;
            cnt = (e1 / (p + 1)) % (n + 1);
            exp_pwm = (cnt < cmpe) ^ pol;
            exp_irq = ien && ((e - t0) >= w);
            chk_val("pwm", 32'(pwm_out), 32'(exp_pwm));
            chk_val("irq", 32'(irq), 32'(exp_irq));
            if ((e - t0) >= 3 && (e - t0) <= 22 && pwm_out) hi++;
            if (mid > 0 && (e - t0) == mid) begin
                bus.adr = A_CMP; bus.we = 1'b1; bus.dat_w = 32'(cnew); bus.sel = 4'hF;
                bus.cyc = 1'b1; bus.stb = 1'b1;
                tw = e + 1;
            end
        end
        bus_idle();
        if (exp_hi >= 0) chk_val("duty_hi", 32'(hi), 32'(exp_hi));
        wr(A_CTRL, 32'(int'(pol) << 1), 4'hF);
        rd_chk("count_dis", A_COUNT, 32'h0);
        chk_val("pwm_dis", 32'(pwm_out), 32'(pol));
        $display("trial p=%0d n=%0d c=%0d pol=%0b ien=%0b done", p, n, c, pol, ien);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int e;
        bus.adr = '0; bus.dat_w = '0; bus.sel = '0; bus_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset during an outstanding write: write is lost, ack never seen.
        @(posedge clk); #1;
        bus.adr = A_CTRL; bus.we = 1'b1; bus.dat_w = 32'h7; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_val("rst_ack", 32'({bus.ack, bus.err}), 32'd0);
        @(posedge clk); #1;
        chk_val("rst_ack2", 32'({bus.ack, bus.err}), 32'd0);
        bus_idle();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) rd_chk("rst_reg", 32'(i * 4), 32'h0);
        chk_val("rst_pwm", 32'(pwm_out), 32'd0);
        chk_val("rst_irq", 32'(irq), 32'd0);

        wr(A_CTRL, 32'h7, 4'hF);
        wr(A_PRE, 32'h3, 4'hF);
        wr(A_PER, 32'h9, 4'hF);
        wr(A_CMP, 32'h4, 4'hF);
        rd_chk("rb_ctrl", A_CTRL, 32'h7);
        rd_chk("rb_pre", A_PRE, 32'h3);
        rd_chk("rb_per", A_PER, 32'h9);
        rd_chk("rb_cmp", A_CMP, 32'h4);
        wr(A_CTRL, 32'h0, 4'hF);

        rd_chk("err_18", 32'h18, 32'h0);
        rd_chk("err_1c", 32'h1C, 32'h0);
        wr(32'h18, 32'hFFFF_FFFF, 4'hF);
        wr(A_PRE, 32'h1234, 4'hF);
        wr(A_PRE, 32'hAABB, 4'b0010);
        rd_chk("byte_lane", A_PRE, 32'hAA34);
        wr(A_COUNT, 32'h55, 4'hF);
        rd_chk("count_ro", A_COUNT, 32'h0);

        run_trial(1, 9, 3, 1'b0, 1'b1, 30, 7, 70, 6);
        run_trial(0, 0, 0, 1'b0, 1'b1, 0, 0, 12, -1);
        run_trial(0, 5, 0, 1'b1, 1'b0, 0, 0, 20, -1);
        run_trial(2, 5, 16'hFFFF, 1'b0, 1'b1, 0, 0, 30, -1);
        run_trial(0, 5, 16'hFFFF, 1'b1, 1'b0, 0, 0, 20, -1);
        run_trial(0, 0, 1, 1'b1, 1'b1, 0, 0, 10, -1);
        for (int t = 0; t < 8; t++) begin
            int rp, rn, rc;
            rp = int'($urandom_range(0, 3));
            rn = int'($urandom_range(0, 7));
            rc = int'($urandom_range(0, 9));
            run_trial(rp, rn, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      0, 0, 2 * (rp + 1) * (rn + 1) + 10, -1);
        end

        // Wrap on every edge, so any clear collides with a set.
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_PRE, 32'h0, 4'hF);
        wr(A_PER, 32'h0, 4'hF);
        wr(A_CMP, 32'h0, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        @(posedge clk); #1;
        chk_val("irq_set", 32'(irq), 32'd1);
        wb_xfer(A_STAT, 1'b1, 32'h1, 4'b0001, d, e);
        chk_val("w1c_collide", 32'(last_irq), 32'd1);
        rd_chk("wrap_kept", A_STAT, 32'h1);

        wr(A_CTRL, 32'h4, 4'hF);
        wr(A_STAT, 32'hFFFF_FFFF, 4'b1110);
        rd_chk("w1c_nosel", A_STAT, 32'h1);
        chk_val("irq_nosel", 32'(irq), 32'd1);
        wb_xfer(A_STAT, 1'b1, 32'h1, 4'b0001, d, e);
        chk_val("w1c_irq", 32'(last_irq), 32'd0);
        rd_chk("w1c_stat", A_STAT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
